// File: rtl/usreg_ctrl_pkg.sv
// Shared encodings for the usreg sequencing controller: usreg sel codes and FSM states.
package usreg_ctrl_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/usreg_bit_cnt.sv
// Clear/enable bit counter; term_o flags the count value WIDTH-1.
module usreg_bit_cnt #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign term_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/usreg_ser_ctrl.sv
// Parallel-to-serial sequencer driving a universal shift register (load, then WIDTH shifts).
// Optional macro USR_CTRL_ROTATE_EN feeds the exiting bit back as serial_in instead of fill_bit.
module usreg_ser_ctrl
    import usreg_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    input  logic             fill_bit,
    input  logic [WIDTH-1:0] sr_q,
    output logic [1:0]       sr_sel,
    output logic [WIDTH-1:0] sr_d,
    output logic             sr_si,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    ctrl_state_e      state_q, state_d;
    logic [WIDTH-1:0] word_q;
    logic             msb_q;
    logic             fill_q;
    logic             accept;
    logic             cnt_term;
    logic             exit_bit;
    logic             shift_si;

    assign accept = (state_q == IDLE) && in_valid && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (cnt_term) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Direction and fill are frozen at accept so upstream may move on while the word drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            msb_q  <= 1'b0;
            fill_q <= 1'b0;
        end else if (accept) begin
            word_q <= in_data;
            msb_q  <= msb_first;
            fill_q <= fill_bit;
        end
    end

    usreg_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != SHIFT),
        .en_i   (state_q == SHIFT),
        .term_o (cnt_term)
    );

    assign exit_bit = msb_q ? sr_q[WIDTH-1] : sr_q[0];

`ifdef USR_CTRL_ROTATE_EN
    assign shift_si = exit_bit;
`else
    assign shift_si = fill_q;
`endif

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        in_ready  = 1'b0;
        sr_sel    = SEL_HOLD;
        sr_d      = '0;
        sr_si     = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: in_ready = !rst;
            LOAD: begin
                sr_sel = SEL_LOAD;
                sr_d   = word_q;
                busy   = 1'b1;
            end
            SHIFT: begin
                sr_sel    = msb_q ? SEL_SHL : SEL_SHR;
                sr_si     = shift_si;
                ser_out   = exit_bit;
                ser_valid = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usreg_ser_ctrl.sv
// Self-checking bench: controller plus a behavioural usreg, directed and random words vs. a word-level model.
module tb_usreg_ser_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         msb_first = 1'b0;
    logic         fill_bit = 1'b0;
    logic [W-1:0] sr_q;
    logic [1:0]   sr_sel;
    logic [W-1:0] sr_d;
    logic         sr_si;
    logic         ser_out;
    logic         ser_valid;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int accept_cyc[$];

    always #5 clk = ~clk;

    usreg_ser_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .msb_first (msb_first),
        .fill_bit  (fill_bit),
        .sr_q      (sr_q),
        .sr_sel    (sr_sel),
        .sr_d      (sr_d),
        .sr_si     (sr_si),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural universal shift register, the device this controller drives.
    logic [W-1:0] usreg_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            usreg_q <= '0;
        else
            case (sr_sel)
                2'b01:   usreg_q <= {sr_si, usreg_q[W-1:1]};
                2'b10:   usreg_q <= {usreg_q[W-2:0], sr_si};
                2'b11:   usreg_q <= sr_d;
                default: usreg_q <= usreg_q;
            endcase
    end
    assign sr_q = usreg_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) accept_cyc.push_back(cyc);
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; waits for in_ready, hands one word over and checks the whole transaction.
    task automatic send_word(input logic [W-1:0] w, input logic msb, input logic fill,
                             input bit keep_valid, input logic [W-1:0] next_data);
        int n = 0;
        logic [W-1:0] exp_final;
        logic         exp_bit;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_data   = w;
        msb_first = msb;
        fill_bit  = fill;
        @(posedge clk);
        @(negedge clk);
        if (keep_valid) begin
            in_data = next_data;
        end else begin
            in_valid  = 1'b0;
            in_data   = W'($urandom);
            msb_first = $urandom_range(0, 1);
            fill_bit  = $urandom_range(0, 1);
        end
        check("load_sel", {30'd0, sr_sel}, 32'd3);
        check("load_d", {28'd0, sr_d}, {28'd0, w});
        check("load_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            exp_bit = msb ? w[W-1-i] : w[i];
            check("shift_valid", {31'd0, ser_valid}, 32'd1);
            check("shift_sel", {30'd0, sr_sel}, msb ? 32'd2 : 32'd1);
            check("ser_out", {31'd0, ser_out}, {31'd0, exp_bit});
        end
        @(negedge clk);
`ifdef USR_CTRL_ROTATE_EN
        exp_final = w;
`else
        exp_final = {W{fill}};
`endif
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_sel", {30'd0, sr_sel}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd1);
        check("done_ready", {31'd0, in_ready}, 32'd0);
        check("final_q", {28'd0, sr_q}, {28'd0, exp_final});
        @(negedge clk);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_ready", {31'd0, in_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int d0;
        #3;
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_sel", {30'd0, sr_sel}, 32'd0);
        check("rst_outs", {28'd0, sr_d, sr_si, ser_out, ser_valid, busy, done},
              32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready", {31'd0, in_ready}, 32'd1);
        check("rel_sel", {30'd0, sr_sel}, 32'd0);
        @(negedge clk);

        send_word(4'b1010, 1'b0, 1'b1, 1'b0, '0);
        send_word(4'b1010, 1'b1, 1'b0, 1'b0, '0);

        // Held in_valid: the second word is taken on the first IDLE cycle.
        send_word(4'b0011, 1'b0, 1'b0, 1'b1, 4'b1100);
        send_word(4'b1100, 1'b1, 1'b1, 1'b0, '0);
        check("accept_spacing", 32'(accept_cyc[$] - accept_cyc[$-1]), 32'd7);

        // Abort after two serial bits.
        @(negedge clk);
        d0 = done_cnt;
        in_valid = 1'b1; in_data = 4'b1010; msb_first = 1'b0; fill_bit = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_bit0", {31'd0, ser_out}, 32'd0);
        @(negedge clk);
        check("abort_bit1", {31'd0, ser_out}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_sel", {30'd0, sr_sel}, 32'd0);
        check("abort_valid", {31'd0, ser_valid}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        send_word(4'b0110, 1'b0, 1'b0, 1'b0, '0);
        send_word(4'b0110, 1'b0, 1'b1, 1'b0, '0);

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_word(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
